// File: rtl/seg7_display_decoder.sv
// Reads back two 7-segment buses, filters for stability, decodes to a 0-99 value
// and reports each new stable reading, flagging blank and illegal glyphs.
module seg7_display_decoder #(
    parameter int STABLE_CYCLES = 16,
    parameter bit ACTIVE_LOW    = 1'b1
) (
    input  logic       i_Clk,
    input  logic       i_Rst,
    input  logic [6:0] i_Seg1,
    input  logic [6:0] i_Seg2,
    output logic [3:0] o_Digit1,
    output logic [3:0] o_Digit2,
    output logic [6:0] o_Value,
    output logic       o_Valid,
    output logic       o_Blank,
    output logic       o_Glyph_Err,
    output logic [7:0] o_Update_Count
);

    localparam int CW = (STABLE_CYCLES > 2) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    localparam logic [1:0] S_TRACK  = 2'd0;
    localparam logic [1:0] S_DECODE = 2'd1;
    localparam logic [1:0] S_REPORT = 2'd2;

    // Synchroniser resets to the pin level of an all-dark display, so W starts dark.
    localparam logic [13:0] SYNC_RST = {14{ACTIVE_LOW}};

    // Decoded glyph: {illegal, blank, digit[3:0]}
    function automatic logic [5:0] decode_glyph(input logic [6:0] g);
        case (g)
            7'b1111110: decode_glyph = {2'b00, 4'd0};
            7'b0110000: decode_glyph = {2'b00, 4'd1};
            7'b1101101: decode_glyph = {2'b00, 4'd2};
            7'b1111001: decode_glyph = {2'b00, 4'd3};
            7'b0110011: decode_glyph = {2'b00, 4'd4};
            7'b1011011: decode_glyph = {2'b00, 4'd5};
            7'b1011111: decode_glyph = {2'b00, 4'd6};
            7'b1110000: decode_glyph = {2'b00, 4'd7};
            7'b1111111: decode_glyph = {2'b00, 4'd8};
            7'b1111011: decode_glyph = {2'b00, 4'd9};
            7'b0000000: decode_glyph = {2'b01, 4'd0};
            default:    decode_glyph = {2'b10, 4'd0};
        endcase
    endfunction

    logic [13:0]   sync1_q, sync2_q, wprev_q, c_q, w;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    state_q, state_d;
    logic [5:0]    dec1_q, dec2_q;
    logic          load;
    logic          rep_ok, rep_blank;
    logic [3:0]    tens, ones;
    logic [6:0]    tens7, val_d;

    assign w = sync2_q ^ {14{ACTIVE_LOW}};

    always_comb begin
        cnt_d = cnt_q;
        if (w != wprev_q)
            cnt_d = '0;
        else if (cnt_q != CNT_MAX)
            cnt_d = cnt_q + 1'b1;
    end

    // Acting on the counter's next value lets C load on the edge the count completes.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            S_TRACK: begin
                if (cnt_d == CNT_MAX && w != c_q) begin
                    load    = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_REPORT;
            S_REPORT: state_d = S_TRACK;
            default:  state_d = S_TRACK;
        endcase
    end

    // A blank tens digit is a leading blank and reads as 0.
    assign tens      = dec1_q[4] ? 4'd0 : dec1_q[3:0];
    assign ones      = dec2_q[3:0];
    assign rep_ok    = !dec2_q[5] && !dec2_q[4] && !dec1_q[5];
    assign rep_blank = dec1_q[4] && dec2_q[4];
    assign tens7     = {3'b000, tens};
    assign val_d     = (tens7 << 3) + (tens7 << 1) + {3'b000, ones};

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            sync1_q <= SYNC_RST;
            sync2_q <= SYNC_RST;
            wprev_q <= '0;
            cnt_q   <= '0;
            state_q <= S_TRACK;
            c_q     <= '0;
            dec1_q  <= '0;
            dec2_q  <= '0;
        end else begin
            sync1_q <= {i_Seg1, i_Seg2};
            sync2_q <= sync1_q;
            wprev_q <= w;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            if (load)
                c_q <= w;
            if (state_q == S_DECODE) begin
                dec1_q <= decode_glyph(c_q[13:7]);
                dec2_q <= decode_glyph(c_q[6:0]);
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            o_Digit1       <= '0;
            o_Digit2       <= '0;
            o_Value        <= '0;
            o_Valid        <= 1'b0;
            o_Blank        <= 1'b0;
            o_Glyph_Err    <= 1'b0;
            o_Update_Count <= '0;
        end else begin
            o_Valid <= 1'b0;
            if (state_q == S_REPORT) begin
                if (rep_ok) begin
                    o_Digit1       <= tens;
                    o_Digit2       <= ones;
                    o_Value        <= val_d;
                    o_Valid        <= 1'b1;
                    o_Update_Count <= o_Update_Count + 8'd1;
                    o_Blank        <= 1'b0;
                    o_Glyph_Err    <= 1'b0;
                end else if (rep_blank) begin
                    o_Blank     <= 1'b1;
                    o_Glyph_Err <= 1'b0;
                end else begin
                    o_Blank     <= 1'b0;
                    o_Glyph_Err <= 1'b1;
                end
            end
        end
    end

endmodule
